upg_word_loader: RTL and testbench
==================================

# upg_word_loader

Byte-to-word assembler for the UART programmer path. It consumes the received byte stream from the UART receiver on the programmer clock and parses a simple load frame. It drives the `upg_*` write port shared by instruction and data memory: one write strobe per assembled 32-bit word, then `upg_done_o`, which hands both memories back to the CPU clock domain.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: inter-byte timeout in `upg_clk_i` cycles, which is 100 ms at 10 MHz. Must be ≥ 2.
- `upg_clk_i` in 1: programmer clock (10 MHz). Single clock domain.
- `upg_rst_i` in 1: reset, synchronous, active-high.
- `rx_valid_i` in 1: one-cycle pulse, `rx_byte_i` valid this cycle.
- `rx_byte_i` in 8: received byte.
- `upg_wen_o` out 1: one-cycle memory write strobe.
- `upg_sel_o` out 1: target memory, 0 = instruction, 1 = data.
- `upg_adr_o` out 14: word address.
- `upg_dat_o` out 32: word to write.
- `upg_done_o` out 1: programming finished. Held until reset.
- `upg_err_o` out 1: frame error. Held until reset.

## Operation
- Frame format, in byte order:
  - header: 0x00 = instruction memory, 0x01 = data memory
  - count low byte, then count high byte: N words
  - 4·N data bytes, each word little-endian (first byte → `dat[7:0]`)
- State machine: `IDLE → CNT_LO → CNT_HI → DATA → DONE`, plus `ERR`. Only cycles with `rx_valid_i=1` advance the state.
- **IDLE**: on a byte:
  - 0x00 or 0x01: latch `upg_sel_o` ← bit0, go to `CNT_LO`.
  - any other value: go to `ERR`.
- **CNT_LO**: latch `count[7:0]`.
- **CNT_HI**: latch `count[15:8]`, then:
  - count > 16384: go to `ERR`.
  - count == 0: go to `DONE`.
  - otherwise: clear word index and byte index, go to `DATA`.
- **DATA**:
  - 2-bit byte index selects the byte lane of the shift/assembly register.
  - On the 4th byte: present the word, pulse `upg_wen_o`, and increment the word index.
  - When the index reaches count: go to `DONE`.
- `upg_adr_o` equals the word index: 0 for the first word, count−1 for the last. It is 14 bits; a count of 16384 ends exactly at 0x3FFF and never wraps.
- **DONE**: `upg_done_o`=1. All bytes are ignored until reset, and no further frame is accepted.
- **ERR**: `upg_err_o`=1, `upg_done_o`=0, `upg_wen_o` never asserts. All bytes are ignored until reset.
- Timeout:
  - In `CNT_LO`, `CNT_HI` or `DATA`, a counter increments on every cycle without `rx_valid_i` and clears on every byte.
  - Reaching `TIMEOUT_CYCLES` goes to `ERR`. A partial word is discarded and never written.
  - No timeout applies in `IDLE`, `DONE` or `ERR`.
- Reset, at any time including mid-word: state → `IDLE`; all counters, indices and the partial word cleared; all outputs at reset values.

## Timing
- Reset values:
  - `upg_wen_o`=0, `upg_sel_o`=0, `upg_adr_o`=0, `upg_dat_o`=0, `upg_done_o`=0, `upg_err_o`=0.
  - Internal: state `IDLE`, timeout counter 0.
- All outputs are registered.
- Write latency:
  - The 4th data byte is accepted at cycle t.
  - At t+1: `upg_wen_o`=1 for exactly one cycle, with `upg_adr_o` and `upg_dat_o` valid the same cycle.
  - `upg_adr_o` and `upg_dat_o` hold until the next word's strobe.
- `upg_adr_o` updates to the next index only together with the next strobe. It never changes while `upg_wen_o`=1.
- Done ordering:
  - After the last word, `upg_done_o` rises at t+2: one cycle after the final `upg_wen_o` pulse, never in the same cycle, so the last write lands on `upg_clk_i` before memory switches clocks.
  - For count == 0, `upg_done_o` rises the cycle after the `CNT_HI` byte is accepted.
- `ERR` entry:
  - `upg_err_o` rises the cycle after the offending byte.
  - On timeout, it rises the cycle after the counter reaches `TIMEOUT_CYCLES`.
- Throughput: back-to-back `rx_valid_i` on consecutive cycles must be accepted with no byte lost, since the receiver has no backpressure.

## Test plan
- **Data-memory load.** Bytes 01 02 00 78 56 34 12 EF BE AD DE → exactly two strobes:
  - sel=1, adr=0x0000, dat=0x12345678
  - adr=0x0001, dat=0xDEADBEEF
  - `upg_done_o`=1 one cycle after the 2nd strobe; err=0.
- **Zero count.** 00 00 00 → no strobe, sel=0, `upg_done_o`=1 the cycle after the 3rd byte.
- **Bad header and oversize count.**
  - Header 0x05 → `upg_err_o`=1 next cycle.
  - After reset, 00 01 40 (count 16385) → `upg_err_o`=1.
  - No strobes in either case, and later bytes are ignored.
- **Timeout** (`TIMEOUT_CYCLES`=16). Send 01 01 00 AA BB, then idle 16 cycles → `upg_err_o`=1, no strobe, `upg_done_o` stays 0.
- **Reset mid-word.** Send 00 01 00 11 22, assert `upg_rst_i` for 1 cycle, then send 00 01 00 44 33 22 11 → a single strobe with adr=0, dat=0x11223344, followed by done.
- **Back-to-back and post-DONE.**
  - Full 4-word frame with `rx_valid_i` high every cycle → 4 strobes at adr 0..3 with correct data.
  - Extra bytes after `DONE` → no strobe; done and err unchanged.

Source files
------------

// File: rtl/upg_word_loader.sv
// UART programmer byte-to-word loader: parses a load frame and drives the shared
// upg_* memory write port, one strobe per little-endian 32-bit word.
module upg_word_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        upg_clk_i,
   input  logic        upg_rst_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_byte_i,
   output logic        upg_wen_o,
   output logic        upg_sel_o,
   output logic [13:0] upg_adr_o,
   output logic [31:0] upg_dat_o,
   output logic        upg_done_o,
   output logic        upg_err_o
);

   localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned IDX_W   = 15;
   localparam int unsigned ADR_W   = 14;
   localparam int unsigned MAX_CNT = 16384;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_LO,
      S_CNT_HI,
      S_DATA,
      S_DONE,
      S_ERR
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [IDX_W-1:0]   widx_q, widx_d;
   logic [1:0]         bidx_q, bidx_d;
   logic [23:0]        asm_q, asm_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               wen_q, wen_d;
   logic               sel_q, sel_d;
   logic [ADR_W-1:0]   adr_q, adr_d;
   logic [31:0]        dat_q, dat_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               tmo_hit;
   logic [CNT_W-1:0]   cnt_full;

   assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYCLES));
   assign cnt_full = {rx_byte_i, count_q[7:0]};

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      widx_d  = widx_q;
      bidx_d  = bidx_q;
      asm_d   = asm_q;
      tmo_d   = '0;
      wen_d   = 1'b0;
      sel_d   = sel_q;
      adr_d   = adr_q;
      dat_d   = dat_q;

      // Inter-byte timeout only runs while a frame is in progress
      if (state_q == S_CNT_LO || state_q == S_CNT_HI || state_q == S_DATA) begin
         tmo_d = rx_valid_i ? '0 : tmo_q + TMO_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (rx_valid_i) begin
               if (rx_byte_i[7:1] == 7'd0) begin
                  sel_d   = rx_byte_i[0];
                  state_d = S_CNT_LO;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_CNT_LO: begin
            if (tmo_hit) begin
               state_d = S_ERR;
            end else if (rx_valid_i) begin
               count_d[7:0] = rx_byte_i;
               state_d      = S_CNT_HI;
            end
         end
         S_CNT_HI: begin
            if (tmo_hit) begin
               state_d = S_ERR;
            end else if (rx_valid_i) begin
               count_d = cnt_full;
               if (cnt_full > CNT_W'(MAX_CNT)) begin
                  state_d = S_ERR;
               end else if (cnt_full == '0) begin
                  state_d = S_DONE;
               end else begin
                  widx_d  = '0;
                  bidx_d  = '0;
                  asm_d   = '0;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            // Index reaching count is checked one cycle after the last strobe,
            // so done trails the final write by a cycle.
            if (CNT_W'(widx_q) == count_q) begin
               state_d = S_DONE;
            end else if (tmo_hit) begin
               state_d = S_ERR;
            end else if (rx_valid_i) begin
               if (bidx_q == 2'd3) begin
                  wen_d  = 1'b1;
                  adr_d  = widx_q[ADR_W-1:0];
                  dat_d  = {rx_byte_i, asm_q};
                  widx_d = widx_q + IDX_W'(1);
                  bidx_d = '0;
               end else begin
                  case (bidx_q)
                     2'd0:    asm_d[7:0]   = rx_byte_i;
                     2'd1:    asm_d[15:8]  = rx_byte_i;
                     default: asm_d[23:16] = rx_byte_i;
                  endcase
                  bidx_d = bidx_q + 2'd1;
               end
            end
         end
         S_DONE:  state_d = S_DONE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_ERR;
      endcase

      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERR);
   end

   // State and output registers
   always_ff @(posedge upg_clk_i) begin
      if (upg_rst_i) begin
         state_q <= S_IDLE;
         count_q <= '0;
         widx_q  <= '0;
         bidx_q  <= '0;
         asm_q   <= '0;
         tmo_q   <= '0;
         wen_q   <= 1'b0;
         sel_q   <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         widx_q  <= widx_d;
         bidx_q  <= bidx_d;
         asm_q   <= asm_d;
         tmo_q   <= tmo_d;
         wen_q   <= wen_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign upg_wen_o  = wen_q;
   assign upg_sel_o  = sel_q;
   assign upg_adr_o  = adr_q;
   assign upg_dat_o  = dat_q;
   assign upg_done_o = done_q;
   assign upg_err_o  = err_q;

endmodule

// File: tb/tb_upg_word_loader.sv
// Bench for upg_word_loader: directed frames plus randomized frames checked
// against a frame-level parser model.
module tb_upg_word_loader;

   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        wen, sel, done, err;
   logic [13:0] adr;
   logic [31:0] dat;

   int total = 0;
   int bad = 0;

   upg_word_loader #(.TIMEOUT_CYCLES(TMO)) dut (
      .upg_clk_i(clk), .upg_rst_i(rst), .rx_valid_i(rx_valid), .rx_byte_i(rx_byte),
      .upg_wen_o(wen), .upg_sel_o(sel), .upg_adr_o(adr), .upg_dat_o(dat),
      .upg_done_o(done), .upg_err_o(err)
   );

   always #5 clk = ~clk;

   // Cycle counter and output monitor
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        mon_clr = 1'b1;
   logic [13:0] got_adr[$];
   logic [31:0] got_dat[$];
   logic        got_sel[$];
   int last_wen_cyc = -1, done_rise_cyc = -1, err_rise_cyc = -1, wen_viol = 0;
   logic wen_prev = 1'b0, done_prev = 1'b0, err_prev = 1'b0;

   always @(negedge clk) begin
      if (mon_clr) begin
         got_adr.delete(); got_dat.delete(); got_sel.delete();
         last_wen_cyc = -1; done_rise_cyc = -1; err_rise_cyc = -1; wen_viol = 0;
      end else begin
         if (wen === 1'b1) begin
            got_adr.push_back(adr); got_dat.push_back(dat); got_sel.push_back(sel);
            last_wen_cyc = cyc;
            if (wen_prev || err) wen_viol++;
         end
         if (done === 1'b1 && !done_prev) done_rise_cyc = cyc;
         if (err === 1'b1 && !err_prev) err_rise_cyc = cyc;
      end
      wen_prev  = (wen === 1'b1);
      done_prev = (done === 1'b1);
      err_prev  = (err === 1'b1);
   end

   // Frame-level reference: parse header, count and little-endian words
   logic [13:0] exp_adr[$];
   logic [31:0] exp_dat[$];
   logic        exp_sel, exp_done, exp_err;

   function automatic void model(input logic [7:0] b[$]);
      int n;
      exp_adr.delete(); exp_dat.delete();
      exp_sel = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
      if (b.size() == 0) return;
      if (b[0] > 8'd1) begin exp_err = 1'b1; return; end
      exp_sel = (b[0] == 8'd1);
      if (b.size() < 3) return;
      n = int'(b[1]) + 256 * int'(b[2]);
      if (n > 16384) begin exp_err = 1'b1; return; end
      for (int w = 0; w < n; w++) begin
         if (3 + 4 * w + 3 >= b.size()) return;
         exp_adr.push_back(14'(w));
         exp_dat.push_back({b[3+4*w+3], b[3+4*w+2], b[3+4*w+1], b[3+4*w]});
      end
      exp_done = 1'b1;
   endfunction

   int last_drive = 0;

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; mon_clr = 1'b1; rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0; mon_clr = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1; rx_byte = b; last_drive = cyc;
      @(negedge clk);
      rx_valid = 1'b0; rx_byte = 8'h00;
   endtask

   task automatic run_frame(input logic [7:0] f[$], input int max_gap);
      foreach (f[i]) begin
         send_byte(f[i]);
         repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      settle(1);
      total++;
      if ({wen, sel, adr, dat, done, err} !== 50'd0) begin
         bad++; $display("FAIL reset_outputs got=%h exp=0", {wen, sel, adr, dat, done, err});
      end
   endtask

   task automatic test_data_load();
      logic [7:0] fr[$];
      apply_reset();
      fr = '{8'h01, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_frame(fr, 0);
      settle(4);
      total++;
      if (got_dat.size() != 2) begin bad++; $display("FAIL dl_count got=%0d exp=2", got_dat.size()); end
      if (got_dat.size() == 2) begin
         total++;
         if ({got_sel[0], got_adr[0], got_dat[0]} !== {1'b1, 14'h0, 32'h12345678}) begin
            bad++; $display("FAIL dl_word0 got=%h/%h/%h exp=1/0000/12345678", got_sel[0], got_adr[0], got_dat[0]);
         end
         total++;
         if ({got_adr[1], got_dat[1]} !== {14'h1, 32'hDEADBEEF}) begin
            bad++; $display("FAIL dl_word1 got=%h/%h exp=0001/deadbeef", got_adr[1], got_dat[1]);
         end
      end
      total++;
      if (last_wen_cyc != last_drive + 1) begin
         bad++; $display("FAIL dl_wen_latency got=%0d exp=%0d", last_wen_cyc, last_drive + 1);
      end
      total++;
      if (done_rise_cyc != last_wen_cyc + 1) begin
         bad++; $display("FAIL dl_done_timing got=%0d exp=%0d", done_rise_cyc, last_wen_cyc + 1);
      end
      total++;
      if ({done, err, adr, dat, wen_viol} !== {1'b1, 1'b0, 14'h1, 32'hDEADBEEF, 32'd0}) begin
         bad++; $display("FAIL dl_final got=%b/%b/%h/%h/%0d exp=1/0/0001/deadbeef/0", done, err, adr, dat, wen_viol);
      end
   endtask

   task automatic test_zero_count();
      logic [7:0] fr[$];
      apply_reset();
      fr = '{8'h00, 8'h00, 8'h00};
      run_frame(fr, 0);
      settle(3);
      total++;
      if (done_rise_cyc != last_drive + 1) begin
         bad++; $display("FAIL zc_done_timing got=%0d exp=%0d", done_rise_cyc, last_drive + 1);
      end
      total++;
      if ({got_dat.size() == 0, sel, done, err} !== 4'b1010) begin
         bad++; $display("FAIL zc_state got=strobes %0d sel %b done %b err %b exp=0/0/1/0", got_dat.size(), sel, done, err);
      end
   endtask

   task automatic test_bad_header();
      logic [7:0] fr[$];
      apply_reset();
      send_byte(8'h05);
      settle(2);
      total++;
      if (err_rise_cyc != last_drive + 1) begin
         bad++; $display("FAIL bh_err_timing got=%0d exp=%0d", err_rise_cyc, last_drive + 1);
      end
      fr = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      run_frame(fr, 0);
      settle(4);
      total++;
      if ({got_dat.size() == 0, done, err} !== 3'b101) begin
         bad++; $display("FAIL bh_ignore got=strobes %0d done %b err %b exp=0/0/1", got_dat.size(), done, err);
      end
   endtask

   task automatic test_oversize();
      logic [7:0] fr[$];
      apply_reset();
      fr = '{8'h00, 8'h00, 8'h40, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
      run_frame(fr, 0);
      settle(2);
      total++;
      if ({err, got_dat.size() == 1} !== 2'b01 || got_dat.size() != 1 || got_dat[0] !== 32'hD4C3B2A1) begin
         bad++; $display("FAIL os_max_count got=err %b strobes %0d exp=0/1 word d4c3b2a1", err, got_dat.size());
      end
      apply_reset();
      fr = '{8'h00, 8'h01, 8'h40};
      run_frame(fr, 0);
      settle(1);
      total++;
      if (err_rise_cyc != last_drive + 1) begin
         bad++; $display("FAIL os_err_timing got=%0d exp=%0d", err_rise_cyc, last_drive + 1);
      end
      fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      run_frame(fr, 0);
      settle(4);
      total++;
      if ({got_dat.size() == 0, done, err} !== 3'b101) begin
         bad++; $display("FAIL os_ignore got=strobes %0d done %b err %b exp=0/0/1", got_dat.size(), done, err);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] fr[$];
      apply_reset();
      fr = '{8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB};
      run_frame(fr, 0);
      settle(int'(TMO) + 6);
      total++;
      if (err_rise_cyc != last_drive + 2 + int'(TMO)) begin
         bad++; $display("FAIL to_err_timing got=%0d exp=%0d", err_rise_cyc, last_drive + 2 + int'(TMO));
      end
      total++;
      if ({got_dat.size() == 0, done, err} !== 3'b101) begin
         bad++; $display("FAIL to_state got=strobes %0d done %b err %b exp=0/0/1", got_dat.size(), done, err);
      end
   endtask

   task automatic test_mid_word_reset();
      logic [7:0] fr[$];
      apply_reset();
      fr = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
      run_frame(fr, 0);
      rst = 1'b1; mon_clr = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if ({wen, sel, adr, dat, done, err} !== 50'd0) begin
         bad++; $display("FAIL mr_reset_outputs got=%h exp=0", {wen, sel, adr, dat, done, err});
      end
      rst = 1'b0; mon_clr = 1'b0;
      fr = '{8'h00, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
      run_frame(fr, 0);
      settle(4);
      total++;
      if (got_dat.size() != 1 || got_adr[0] !== 14'h0 || got_dat[0] !== 32'h11223344) begin
         bad++; $display("FAIL mr_word got=strobes %0d exp=1 at 0000 data 11223344", got_dat.size());
      end
      total++;
      if ({done, err} !== 2'b10 || done_rise_cyc != last_wen_cyc + 1) begin
         bad++; $display("FAIL mr_done got=%b%b rise %0d exp=10 rise %0d", done, err, done_rise_cyc, last_wen_cyc + 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] fr[$];
      int n_before;
      apply_reset();
      fr = '{8'($urandom_range(1, 0)), 8'h04, 8'h00};
      for (int i = 0; i < 16; i++) fr.push_back(8'($urandom));
      model(fr);
      run_frame(fr, 0);
      settle(3);
      total++;
      if (got_dat.size() != exp_dat.size()) begin
         bad++; $display("FAIL bb_count got=%0d exp=%0d", got_dat.size(), exp_dat.size());
      end else begin
         foreach (exp_dat[i]) begin
            total++;
            if ({got_sel[i], got_adr[i], got_dat[i]} !== {exp_sel, exp_adr[i], exp_dat[i]}) begin
               bad++; $display("FAIL bb_word%0d got=%h/%h/%h exp=%h/%h/%h", i, got_sel[i], got_adr[i], got_dat[i], exp_sel, exp_adr[i], exp_dat[i]);
            end
         end
      end
      n_before = got_dat.size();
      fr.delete();
      for (int i = 0; i < 8; i++) fr.push_back(8'($urandom));
      run_frame(fr, 0);
      settle(3);
      total++;
      if (got_dat.size() != n_before || {done, err} !== 2'b10 || wen_viol != 0) begin
         bad++; $display("FAIL bb_post_done got=strobes %0d done %b err %b viol %0d exp=%0d/1/0/0", got_dat.size(), done, err, wen_viol, n_before);
      end
   endtask

   task automatic test_random_frames();
      logic [7:0] fr[$];
      int n;
      for (int it = 0; it < 8; it++) begin
         apply_reset();
         n = $urandom_range(6, 1);
         fr = '{8'($urandom_range(1, 0)), 8'(n), 8'h00};
         for (int i = 0; i < 4 * n; i++) fr.push_back(8'($urandom));
         model(fr);
         run_frame(fr, 3);
         settle(3);
         total++;
         if (got_dat.size() != exp_dat.size()) begin
            bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, got_dat.size(), exp_dat.size());
         end else begin
            foreach (exp_dat[i]) begin
               total++;
               if ({got_sel[i], got_adr[i], got_dat[i]} !== {exp_sel, exp_adr[i], exp_dat[i]}) begin
                  bad++; $display("FAIL rnd%0d_word%0d got=%h/%h/%h exp=%h/%h/%h", it, i, got_sel[i], got_adr[i], got_dat[i], exp_sel, exp_adr[i], exp_dat[i]);
               end
            end
         end
         total++;
         if ({done, err} !== {exp_done, exp_err} || done_rise_cyc != last_wen_cyc + 1) begin
            bad++; $display("FAIL rnd%0d_done got=%b%b rise %0d exp=%b%b rise %0d", it, done, err, done_rise_cyc, exp_done, exp_err, last_wen_cyc + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_data_load();
      test_zero_count();
      test_bad_header();
      test_oversize();
      test_timeout();
      test_mid_word_reset();
      test_back_to_back();
      test_random_frames();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
